fmap_frame_capture: RTL
=======================

Name: fmap_frame_capture

Overview:
- Synthesizable receive end of the pixel stream (data + 1-bit valid) produced by the conv/maxpool blocks; the hardware counterpart of the bench-side file writer.
- Captures exactly one raster-order feature map of WIDTH x HEIGHT pixels into on-chip memory, then signals frame completion.
- Holds the frame for random-access readout by a downstream consumer (next layer or host) until that consumer releases it.

Parameters:
- DATA_WIDTH, 32, pixel word width (IEEE-754 single).
- WIDTH, 28, pixels per row (post-pool width).
- HEIGHT, 28, rows per frame.
- ADDR_WIDTH, 10, address width; 2^ADDR_WIDTH >= WIDTH*HEIGHT is required.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  synchronous active-low reset
- data_valid_in  input  1  pixel strobe; data_in is valid this cycle
- data_in  input  DATA_WIDTH  pixel value
- frame_release  input  1  consumer has finished with the stored frame; re-arm capture
- rd_en  input  1  read request
- rd_addr  input  ADDR_WIDTH  read address, raster index row*WIDTH+col
- rd_data  output  DATA_WIDTH  read data
- rd_valid  output  1  rd_data valid
- col_cnt  output  ADDR_WIDTH  column of the next pixel to be written
- row_cnt  output  ADDR_WIDTH  row of the next pixel to be written
- full  output  1  a frame is stored and capture is blocked
- done  output  1  one-cycle pulse when a frame completes
- overflow  output  1  sticky flag: a pixel arrived while full

Behaviour:
- Reset (resetn=0 at a clk edge):
  - Outputs: rd_data=0, rd_valid=0, col_cnt=0, row_cnt=0, full=0, done=0, overflow=0.
  - State goes to CAPTURE, write pointer goes to 0.
  - Memory contents are not cleared.
  - Reset mid-capture discards the partial frame; the next valid pixel is written to address 0.
- State machine, two states:
  - CAPTURE:
    - Each cycle with data_valid_in=1 writes data_in to mem[wr_ptr].
    - wr_ptr increments; col_cnt increments.
    - When col_cnt reaches WIDTH-1, col_cnt wraps to 0 and row_cnt increments.
    - Cycles with data_valid_in=0 hold all counters (gaps of any length are allowed).
  - CAPTURE -> READY: on the valid pixel at wr_ptr = WIDTH*HEIGHT-1. That pixel is written.
    - Next cycle: full=1, done=1 for exactly one cycle, wr_ptr/col_cnt/row_cnt = 0.
  - READY:
    - data_valid_in=1 performs no write and sets overflow=1.
    - overflow stays set until reset; frame_release does not clear it.
    - frame_release=1 -> next cycle state=CAPTURE, full=0.
    - A valid pixel in the same cycle as frame_release is still dropped and still sets overflow.
  - frame_release in CAPTURE is ignored.
- Read port (operates in both states):
  - rd_en=1 at edge N -> rd_data = mem[rd_addr] and rd_valid=1 after edge N+1.
  - rd_en=0 -> rd_valid=0 next cycle; rd_data holds its last value.
  - rd_addr >= WIDTH*HEIGHT returns rd_data=0, with rd_valid=1.
  - A read and write to the same address in the same cycle returns the old contents (read-before-write).
- Latency:
  - Write: 1 cycle.
  - done: asserted the cycle after the last pixel is accepted.
  - Read: 1 cycle.
- Memory: WIDTH*HEIGHT words, single write port, single registered read port; must be inferable as block RAM.

Test Plan:
- Reset, then 784 consecutive valid pixels with values 0..783 (WIDTH=HEIGHT=28) -> done pulses once, 1 cycle after pixel 783; full=1. Read addrs 0, 27, 28, 783 return 0, 27, 28, 783 with rd_valid one cycle after rd_en.
- Same stream with valid deasserted 3 cycles after every 10th pixel -> identical memory contents; done fires only after the 784th valid pixel; row_cnt/col_cnt sequence (0,27)->(1,0) is checked at the row wrap.
- While full, drive 5 valid pixels of 0xDEADBEEF -> overflow=1 and stays 1; mem[0] still 0. Pulse frame_release -> full=0 next cycle. A new frame with values 1000+i -> mem[0]=1000, mem[783]=1783.
- Assert resetn=0 for 1 cycle after 400 pixels -> all outputs 0. A new 784-pixel frame then fills addresses 0..783, with done after exactly 784 further pixels.
- rd_addr=900 -> rd_data=0, rd_valid=1. Same-cycle read and write of addr 5 (old value 5, new value 9) -> rd_data=5; a read of addr 5 on the following cycle returns 9.
- frame_release pulsed in CAPTURE mid-frame -> no state change; done still fires at pixel 783.

Source files
------------

// File: rtl/fmap_frame_capture.sv
// Captures one raster-order feature map into on-chip RAM and holds it for
// random-access readout until the consumer releases it.
module fmap_frame_capture #(
    parameter int DATA_WIDTH = 32,
    parameter int WIDTH      = 28,
    parameter int HEIGHT     = 28,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  data_valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  frame_release,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [ADDR_WIDTH-1:0] col_cnt,
    output logic [ADDR_WIDTH-1:0] row_cnt,
    output logic                  full,
    output logic                  done,
    output logic                  overflow
);

    localparam int DEPTH = WIDTH * HEIGHT;

    localparam logic [0:0] CAPTURE = 1'b0;
    localparam logic [0:0] READY   = 1'b1;

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(WIDTH - 1);

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic                  wr_en;
    logic                  in_range;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    assign wr_en    = (state == CAPTURE) && data_valid_in;
    assign full     = (state == READY);
    // Compare at 32 bits so a depth equal to 2^ADDR_WIDTH does not wrap to 0.
    assign in_range = (32'(rd_addr) < 32'(DEPTH));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= CAPTURE;
            wr_ptr   <= '0;
            col_cnt  <= '0;
            row_cnt  <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                CAPTURE: begin
                    if (data_valid_in) begin
                        if (wr_ptr == LAST_PTR) begin
                            state   <= READY;
                            done    <= 1'b1;
                            wr_ptr  <= '0;
                            col_cnt <= '0;
                            row_cnt <= '0;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                            if (col_cnt == COL_LAST) begin
                                col_cnt <= '0;
                                row_cnt <= row_cnt + 1'b1;
                            end else begin
                                col_cnt <= col_cnt + 1'b1;
                            end
                        end
                    end
                end
                READY: begin
                    // Pixels arriving while a frame is held are dropped.
                    if (data_valid_in) begin
                        overflow <= 1'b1;
                    end
                    if (frame_release) begin
                        state <= CAPTURE;
                    end
                end
                default: state <= CAPTURE;
            endcase
        end
    end

    // Storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= in_range ? mem[rd_addr] : '0;
            end
        end
    end

endmodule
